// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: instruction memory that self-clears, accepts a streamed program
// load, then serves registered single-cycle fetches with stall/flush control.
module instr_mem_loadable #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address,
    input  logic              stall,
    input  logic              flush,
    output logic [WIDTH-1:0]  instruction,
    output logic              instr_valid,
    output logic              misaligned,
    output logic              out_of_range,
    output logic              ready,
    output logic              load_overflow
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     clr_ptr_q, clr_ptr_d;
    logic [IW:0]       ld_ptr_q, ld_ptr_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH-1:0]  instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              mis_q, mis_d;
    logic              oor_q, oor_d;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              we;
    logic [IW-1:0]     waddr;
    logic [WIDTH-1:0]  wdata;
    logic              room;
    logic              run;
    logic              fire;
    logic              hold;
    logic              in_range;
    logic [ADDR_W-1:0] word_idx;
    logic [WIDTH-1:0]  rd_word;

    // ld_ptr has one extra bit so ld_ptr == DEPTH means the memory is full
    assign room = !ld_ptr_q[IW];

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ld_ptr_d  = ld_ptr_q;
        ovf_d     = ovf_q;
        we        = 1'b0;
        waddr     = clr_ptr_q;
        wdata     = '0;
        case (state_q)
            CLEAR: begin
                we        = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                state_d   = (clr_ptr_q == IW'(DEPTH - 1)) ? LOAD : CLEAR;
            end
            LOAD: if (load_en) begin
                we       = room;
                waddr    = ld_ptr_q[IW-1:0];
                wdata    = load_data;
                ld_ptr_d = room ? ld_ptr_q + 1'b1 : ld_ptr_q;
                ovf_d    = ovf_q | !room;
                state_d  = load_last ? RUN : LOAD;
            end
            default: ;
        endcase
    end

    // Range check on the full shifted address so high bits cannot alias low words
    assign word_idx = address >> 2;
    assign in_range = word_idx < ADDR_W'(DEPTH);
    assign rd_word  = in_range ? mem[address[IW+1:2]] : '0;
    assign run      = state_q == RUN;
    assign fire     = run && rd_en && !stall && !flush;
    assign hold     = run && stall && !flush;

    always_comb begin
        instr_d = hold ? instr_q : fire ? rd_word : '0;
        valid_d = hold ? valid_q : fire;
        mis_d   = hold ? mis_q   : fire && address[1:0] != 2'b00;
        oor_d   = hold ? oor_q   : fire && !in_range;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            ld_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            mis_q     <= 1'b0;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ld_ptr_q  <= ld_ptr_d;
            ovf_q     <= ovf_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            mis_q     <= mis_d;
            oor_q     <= oor_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign instruction   = instr_q;
    assign instr_valid   = valid_q;
    assign misaligned    = mis_q;
    assign out_of_range  = oor_q;
    assign ready         = run;
    assign load_overflow = ovf_q;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: directed stimulus pushes expected outputs into a queue;
// a negedge monitor pops and compares them against the cycle they are due.
module tb_instr_mem_loadable;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_en = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instruction;
    logic        instr_valid, misaligned, out_of_range, ready, load_overflow;

    typedef struct {
        int          tag;
        logic [31:0] ins;
        logic        v, m, o, r, ov;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic exp_rdy = 1'b0;
    logic exp_ovf = 1'b0;

    instr_mem_loadable dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
        .load_last(load_last), .rd_en(rd_en), .address(address), .stall(stall),
        .flush(flush), .instruction(instruction), .instr_valid(instr_valid),
        .misaligned(misaligned), .out_of_range(out_of_range), .ready(ready),
        .load_overflow(load_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].tag < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_check tag=%0d now=%0d", q[0].tag, cyc);
            void'(q.pop_front());
        end
        if (q.size() != 0 && q[0].tag == cyc) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if ({instruction, instr_valid, misaligned, out_of_range, ready, load_overflow} !==
                {e.ins, e.v, e.m, e.o, e.r, e.ov}) begin
                bad++;
                $display("FAIL out@%0d got ins=%h v=%b m=%b o=%b rdy=%b ovf=%b want ins=%h v=%b m=%b o=%b rdy=%b ovf=%b",
                         cyc, instruction, instr_valid, misaligned, out_of_range, ready, load_overflow,
                         e.ins, e.v, e.m, e.o, e.r, e.ov);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "test done: total=%0d bad=%0d", total, bad);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [31:0] ins, logic v, logic m, logic o);
        exp_t e;
        e.tag = cyc + 1;
        e.ins = ins;
        e.v   = v;
        e.m   = m;
        e.o   = o;
        e.r   = exp_rdy;
        e.ov  = exp_ovf;
        q.push_back(e);
    endtask

    task automatic op(logic rd, logic st, logic fl, logic [31:0] a,
                      logic [31:0] ins, logic v, logic m, logic o);
        rd_en   = rd;
        stall   = st;
        flush   = fl;
        address = a;
        push(ins, v, m, o);
        step();
    endtask

    task automatic fetch(logic [31:0] a, logic [31:0] ins, logic m, logic o);
        op(1'b1, 1'b0, 1'b0, a, ins, 1'b1, m, o);
    endtask

    task automatic load(logic [31:0] d, logic last);
        load_en   = 1'b1;
        load_last = last;
        load_data = d;
        rd_en     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        if (last) exp_rdy = 1'b1;
        push('0, 1'b0, 1'b0, 1'b0);
        step();
        load_en   = 1'b0;
        load_last = 1'b0;
    endtask

    // Assert reset away from any pending capture edge; outputs must clear at once
    task automatic reset_pulse();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({instruction, instr_valid, misaligned, out_of_range, ready, load_overflow} !== '0) begin
            bad++;
            $display("FAIL reset_immediate got ins=%h v=%b m=%b o=%b rdy=%b ovf=%b want all zero",
                     instruction, instr_valid, misaligned, out_of_range, ready, load_overflow);
        end
        step();
        reset   = 1'b0;
        rd_en   = 1'b0;
        exp_rdy = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic reset_count();
        int cnt;
        reset_pulse();
        load_en   = 1'b1;
        load_last = 1'b1;
        load_data = '0;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!ready && cnt < 200);
        load_en   = 1'b0;
        load_last = 1'b0;
        exp_rdy   = 1'b1;
        total++;
        if (cnt != 65) begin
            bad++;
            $display("FAIL ready_latency got %0d cycles want 65", cnt);
        end
    endtask

    initial begin
        // Empty load: only a last word of zero, then every word reads back 0
        reset_count();
        for (int i = 0; i < 64; i++) fetch(32'(i * 4), '0, 1'b0, 1'b0);
        op(1'b0, 1'b0, 1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b0);

        // Three-word program, fetch patterns, stall and flush
        reset_pulse();
        op(1'b1, 1'b0, 1'b0, 32'd0, '0, 1'b0, 1'b0, 1'b0);
        repeat (63) step();
        load(32'h1111_1111, 1'b0);
        load(32'h2222_2222, 1'b0);
        load(32'h3333_3333, 1'b1);
        fetch(32'd8, 32'h3333_3333, 1'b0, 1'b0);
        fetch(32'd6, 32'h2222_2222, 1'b1, 1'b0);
        fetch(32'd256, '0, 1'b0, 1'b1);
        fetch(32'h4000_0000, '0, 1'b0, 1'b1);
        fetch(32'd3, 32'h1111_1111, 1'b1, 1'b0);
        fetch(32'd252, '0, 1'b0, 1'b0);
        load(32'hDEAD_BEEF, 1'b0);
        fetch(32'd12, '0, 1'b0, 1'b0);
        fetch(32'd0, 32'h1111_1111, 1'b0, 1'b0);
        repeat (3) op(1'b1, 1'b1, 1'b0, 32'd4, 32'h1111_1111, 1'b1, 1'b0, 1'b0);
        op(1'b1, 1'b1, 1'b1, 32'd4, '0, 1'b0, 1'b0, 1'b0);
        fetch(32'd4, 32'h2222_2222, 1'b0, 1'b0);
        op(1'b0, 1'b0, 1'b0, 32'd4, '0, 1'b0, 1'b0, 1'b0);

        // 65 words: last one overflows, word 63 keeps the 64th value
        reset_pulse();
        repeat (64) step();
        for (int i = 0; i < 64; i++) load(32'hA000_0000 + 32'(i), 1'b0);
        exp_ovf = 1'b1;
        load(32'hFFFF_FFFF, 1'b1);
        fetch(32'd252, 32'hA000_003F, 1'b0, 1'b0);
        fetch(32'd0, 32'hA000_0000, 1'b0, 1'b0);

        // Reset mid-RUN: progress discarded, memory re-zeroed
        reset_count();
        for (int i = 1; i < 64; i++) fetch(32'(i * 4), '0, 1'b0, 1'b0);

        repeat (3) step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
